// File: rtl/ascii_hex_parser.sv
// ASCII hex token parser: accumulates hex digits into a word, emits it on a separator.
// Optional character echo output enabled by defining ASCII_HEX_ECHO_EN.
module ascii_hex_parser #(
  parameter int DIGITS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_value,
  output logic [$clog2(DIGITS+1)-1:0]  out_count,
`ifdef ASCII_HEX_ECHO_EN
  output logic                         echo_valid,
  output logic [7:0]                   echo_data,
`endif
  output logic                         out_err
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MAXC = CW'(DIGITS);

  typedef enum logic [1:0] {IDLE, ACCUM, SKIP, EMIT} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    val_q, val_d;
  logic [CW-1:0]   ocnt_q, ocnt_d;
  logic            err_q, err_d;
  logic            rdy_q, vld_q;
  logic            is_dig, is_sep, in_xfer, out_xfer;
  logic [3:0]      nib;

  assign in_xfer  = in_valid && rdy_q;
  assign out_xfer = vld_q && out_ready;

  always_comb begin
    is_dig = 1'b0;
    nib    = 4'h0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      is_dig = 1'b1;
      nib    = in_data[3:0];
    end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                 (in_data >= 8'h61 && in_data <= 8'h66)) begin
      is_dig = 1'b1;
      nib    = in_data[3:0] + 4'd9;
    end
    is_sep = (in_data == 8'h20) || (in_data == 8'h0D) || (in_data == 8'h0A);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    ocnt_d  = ocnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_xfer) begin
        if (is_dig) begin
          acc_d   = W'(nib);
          cnt_d   = CW'(1);
          state_d = ACCUM;
        end else if (!is_sep) begin
          state_d = SKIP;
        end
      end
      ACCUM: if (in_xfer) begin
        if (is_sep) begin
          val_d   = acc_q;
          ocnt_d  = cnt_q;
          err_d   = 1'b0;
          state_d = EMIT;
        end else if (is_dig && cnt_q < MAXC) begin
          acc_d = (acc_q << 4) | W'(nib);
          cnt_d = cnt_q + CW'(1);
        end else begin
          // overflow digit or invalid character poisons the token
          state_d = SKIP;
        end
      end
      SKIP: if (in_xfer && is_sep) begin
        val_d   = '0;
        ocnt_d  = '0;
        err_d   = 1'b1;
        state_d = EMIT;
      end
      EMIT: if (out_xfer) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      ocnt_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ocnt_q  <= ocnt_d;
      err_q   <= err_d;
      rdy_q   <= (state_d != EMIT);
      vld_q   <= (state_d == EMIT);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_value = val_q;
  assign out_count = ocnt_q;
  assign out_err   = err_q;

`ifdef ASCII_HEX_ECHO_EN
  logic       echo_vld_q;
  logic [7:0] echo_dat_q;

  // lowercase a-f are folded to uppercase by clearing bit 5
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_vld_q <= 1'b0;
      echo_dat_q <= 8'h00;
    end else begin
      echo_vld_q <= in_xfer;
      if (in_xfer)
        echo_dat_q <= (in_data >= 8'h61 && in_data <= 8'h66) ?
                      {in_data[7:6], 1'b0, in_data[4:0]} : in_data;
    end
  end

  assign echo_valid = echo_vld_q;
  assign echo_data  = echo_dat_q;
`endif

endmodule
